fetch_stage: RTL and testbench

Instruction-fetch front end of the single-issue 32-bit processor. Owns the program counter and drives the synchronous instruction memory (imem) address. Returns each fetched word with its PC to decode, holding it through downstream stalls with a one-entry hold buffer. Takes a PC redirect from execute for resolved `j`, `jal`, `jr` and taken `bne`/`blt`.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_instr_hold_buf.sv | 28 ++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM encoding.
// Imported by the interface, the hold buffer and the fetch_stage top.
package fetch_stage_pkg;

  localparam int               DEF_ADDR_W   = 12;
  localparam logic [11:0]      DEF_RESET_PC = 12'd0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: execute redirect, decode stall, imem address/data and decode-side outputs.
// master = fetch_stage, slave = surrounding pipeline and imem.
interface fetch_stage_if #(
  parameter int ADDR_W = fetch_stage_pkg::DEF_ADDR_W
);

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [31:0]       instr_pc;
  logic [31:0]       instr_pc_plus1;
  logic [31:0]       fetch_count;

  modport master (
    input  stall, redirect, redirect_target, imem_q,
    output imem_addr, instr, instr_valid, instr_pc, instr_pc_plus1, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_target, imem_q,
    input  imem_addr, instr, instr_valid, instr_pc, instr_pc_plus1, fetch_count
  );

endinterface

// File: rtl/fetch_stage_instr_hold_buf.sv
// One-entry hold register for the word presented to decode, plus the instr output mux.
// Loads imem_q when decode stalls, so the word survives imem moving on to the next address.
module instr_hold_buf (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        sel_hold,
  input  logic        sel_mem,
  input  logic [31:0] imem_q,
  output logic [31:0] instr
);

  logic [31:0] hold_buf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_buf <= '0;
    end else if (clear) begin
      hold_buf <= '0;
    end else if (load) begin
      hold_buf <= imem_q;
    end
  end

  assign instr = sel_hold ? hold_buf : (sel_mem ? imem_q : 32'd0);

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, imem address, decode handoff; one word per cycle, 1-cycle imem latency.
// Stall freezes PCs and parks the presented word; redirect beats stall and costs no fetch bubble.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_f, pc_f_nxt;
  logic [ADDR_W-1:0] pc_d, pc_d_nxt;
  logic [ADDR_W-1:0] pc_d_inc;
  logic [31:0]       fetch_count;
  logic              hold_load;
  logic              count_en;

  // Redirect is the only combinational path into imem_addr; stall only acts through pc_f.
  assign bus.imem_addr = bus.redirect ? bus.redirect_target : pc_f;

  always_comb begin
    state_nxt = state;
    pc_f_nxt  = pc_f;
    pc_d_nxt  = pc_d;
    hold_load = 1'b0;
    if (bus.redirect) begin
      state_nxt = RUN;
      pc_d_nxt  = bus.redirect_target;
      pc_f_nxt  = bus.redirect_target + PC_ONE;
    end else begin
      case (state)
        BOOT: begin
          state_nxt = RUN;
          pc_d_nxt  = pc_f;
          pc_f_nxt  = pc_f + PC_ONE;
        end
        RUN: begin
          if (bus.stall) begin
            state_nxt = HOLD;
            hold_load = 1'b1;
          end else begin
            pc_d_nxt = pc_f;
            pc_f_nxt = pc_f + PC_ONE;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            state_nxt = RUN;
            pc_d_nxt  = pc_f;
            pc_f_nxt  = pc_f + PC_ONE;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc_f  <= RESET_PC;
      pc_d  <= '0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_f_nxt;
      pc_d  <= pc_d_nxt;
    end
  end

  assign count_en = bus.instr_valid & ~bus.stall & ~bus.redirect;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (count_en) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  instr_hold_buf u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (hold_load),
    .clear    (bus.redirect),
    .sel_hold (state == HOLD),
    .sel_mem  (state == RUN),
    .imem_q   (bus.imem_q),
    .instr    (bus.instr)
  );

  assign pc_d_inc           = pc_d + PC_ONE;
  assign bus.instr_valid    = (state != BOOT);
  assign bus.instr_pc       = 32'(pc_d);
  assign bus.instr_pc_plus1 = 32'(pc_d_inc);
  assign bus.fetch_count    = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model, per-cycle stimulus table with a scoreboard of next-cycle
// presentations, plus hand-written reset, BOOT and mid-run reset sequences.
module tb_fetch_stage;

  logic clock;
  logic reset;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [4096];
  always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [11:0] target;
    logic [11:0] addr;    // imem_addr expected in the row's own cycle
    logic [11:0] npc;     // PC presented in the following cycle
    logic [31:0] ncount;  // fetch_count in the following cycle
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] count;
  } exp_t;

  vec_t rows [16];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    logic [11:0] p1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries, expected 1");
    end else begin
      e  = sb.pop_front();
      p1 = e.pc + 12'd1;
      check("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("instr", bus.instr, mem[e.pc]);
      check("instr_pc", bus.instr_pc, {20'd0, e.pc});
      check("instr_pc_plus1", bus.instr_pc_plus1, {20'd0, p1});
      check("fetch_count", bus.fetch_count, e.count);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_pc"}, bus.instr_pc, 32'd0);
    check({tag, "_pc_plus1"}, bus.instr_pc_plus1, 32'd1);
    check({tag, "_count"}, bus.fetch_count, 32'd0);
    check({tag, "_addr"}, {20'd0, bus.imem_addr}, 32'd0);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h2840_0005;
    mem[1] = 32'h2880_0003;
    mem[2] = 32'h00C2_2000;
    mem[3] = 32'h28C6_0000;

    //           stall redir target  addr    npc     ncount
    rows[0]  = '{1'b0, 1'b0, 12'd0,    12'd1,    12'd1,    32'd1};
    rows[1]  = '{1'b0, 1'b0, 12'd0,    12'd2,    12'd2,    32'd2};
    rows[2]  = '{1'b1, 1'b0, 12'd0,    12'd3,    12'd2,    32'd2};
    rows[3]  = '{1'b1, 1'b0, 12'd0,    12'd3,    12'd2,    32'd2};
    rows[4]  = '{1'b1, 1'b0, 12'd0,    12'd3,    12'd2,    32'd2};
    rows[5]  = '{1'b0, 1'b0, 12'd0,    12'd3,    12'd3,    32'd3};
    rows[6]  = '{1'b0, 1'b0, 12'd0,    12'd4,    12'd4,    32'd4};
    rows[7]  = '{1'b0, 1'b1, 12'd14,   12'd14,   12'd14,   32'd4};
    rows[8]  = '{1'b0, 1'b0, 12'd0,    12'd15,   12'd15,   32'd5};
    rows[9]  = '{1'b1, 1'b1, 12'd19,   12'd19,   12'd19,   32'd5};
    rows[10] = '{1'b0, 1'b0, 12'd0,    12'd20,   12'd20,   32'd6};
    rows[11] = '{1'b0, 1'b1, 12'd4095, 12'd4095, 12'd4095, 32'd6};
    rows[12] = '{1'b0, 1'b0, 12'd0,    12'd0,    12'd0,    32'd7};
    rows[13] = '{1'b0, 1'b0, 12'd0,    12'd1,    12'd1,    32'd8};
    rows[14] = '{1'b1, 1'b0, 12'd0,    12'd2,    12'd1,    32'd8};
    rows[15] = '{1'b1, 1'b0, 12'd0,    12'd2,    12'd1,    32'd8};

    reset                = 1'b0;
    bus.stall            = 1'b0;
    bus.redirect         = 1'b0;
    bus.redirect_target  = 12'd0;
    @(negedge clock);
    @(negedge clock);
    check_reset_state("rst");

    // Release; stall held high in BOOT must be ignored.
    reset     = 1'b1;
    bus.stall = 1'b1;
    #1;
    check("boot_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("boot_addr", {20'd0, bus.imem_addr}, 32'd0);
    check("boot_instr", bus.instr, 32'd0);
    e.pc = 12'd0; e.count = 32'd0;
    sb.push_back(e);

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check_front();
      bus.stall           = rows[i].stall;
      bus.redirect        = rows[i].redirect;
      bus.redirect_target = rows[i].target;
      e.pc    = rows[i].npc;
      e.count = rows[i].ncount;
      sb.push_back(e);
      #1;
      check($sformatf("imem_addr_row%0d", i), {20'd0, bus.imem_addr}, {20'd0, rows[i].addr});
    end
    @(negedge clock);
    check_front();

    // Mid-run reset while in HOLD: outputs clear asynchronously.
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clock);
    check("midrst_hold_valid", {31'd0, bus.instr_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("restart_boot_valid", {31'd0, bus.instr_valid}, 32'd0);
    e.pc = 12'd0; e.count = 32'd0;
    sb.push_back(e);
    @(negedge clock);
    check_front();
    e.pc = 12'd1; e.count = 32'd1;
    sb.push_back(e);
    @(negedge clock);
    check_front();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
